// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD sum display: active-low 7-segment
// patterns, digit slot index and anode encodings.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic [1:0] {
        IDX_UNITS    = 2'd0,
        IDX_TENS     = 2'd1,
        IDX_HUNDREDS = 2'd2,
        IDX_STATUS   = 2'd3
    } digit_idx_t;

    function automatic digit_idx_t next_digit(input digit_idx_t d);
        case (d)
            IDX_UNITS:    next_digit = IDX_TENS;
            IDX_TENS:     next_digit = IDX_HUNDREDS;
            IDX_HUNDREDS: next_digit = IDX_STATUS;
            default:      next_digit = IDX_UNITS;
        endcase
    endfunction

    function automatic logic bcd_invalid(input logic [7:0] b);
        bcd_invalid = (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_sum_display_if.sv
// Bus between the BCD adder side (master) and the display driver (slave):
// sum strobe/data in, multiplexed 7-segment drive and error flag out.
interface bcd_sum_display_if;

    logic       sum_valid;
    logic [7:0] sum_bcd;
    logic       sum_cout;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       bcd_err;

    modport master (
        output sum_valid, sum_bcd, sum_cout,
        input  seg, dp, an, bcd_err
    );

    modport slave (
        input  sum_valid, sum_bcd, sum_cout,
        output seg, dp, an, bcd_err
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder; non-BCD nibbles show 'E'.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_sum_display.sv
// Captures the BCD adder sum and scans it onto a 4-digit common-anode display
// with a per-slot ghost window. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_sum_display
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GHOST_CYC   = 2
) (
    input  logic               clk,
    input  logic               rst,
    bcd_sum_display_if.slave   bus
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    logic [7:0]    hold_bcd;
    logic          hold_cout;
    logic          err_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          dp_q;

    logic [3:0]    nib;
    logic [6:0]    nib_seg;
    logic [6:0]    slot_seg;
    logic [3:0]    slot_an;

    always_comb begin
        nib = '0;
        case (idx)
            IDX_UNITS:    nib = hold_bcd[3:0];
            IDX_TENS:     nib = hold_bcd[7:4];
            IDX_HUNDREDS: nib = {3'b000, hold_cout};
            default:      nib = '0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nib (nib),
        .seg (nib_seg)
    );

    always_comb begin
        slot_seg = SEG_BLANK;
        slot_an  = AN_OFF;
        case (idx)
            IDX_UNITS: begin
                slot_seg = nib_seg;
                slot_an  = 4'b1110;
            end
            IDX_TENS: begin
                slot_seg = nib_seg;
                slot_an  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                if (!hold_cout && (hold_bcd[7:4] == 4'd0))
                    slot_seg = SEG_BLANK;
`endif
            end
            IDX_HUNDREDS: begin
                slot_seg = nib_seg;
                slot_an  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                if (!hold_cout)
                    slot_seg = SEG_BLANK;
`endif
            end
            default: begin
                slot_seg = err_q ? SEG_E : SEG_BLANK;
                slot_an  = 4'b0111;
            end
        endcase
    end

    // Outputs follow the pre-edge prescaler/idx/hold, so a capture shows on the
    // next registered cycle and a capture at wrap lands before the ghost ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_bcd  <= '0;
            hold_cout <= 1'b0;
            err_q     <= 1'b0;
            presc     <= '0;
            idx       <= IDX_UNITS;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            dp_q      <= 1'b1;
        end else begin
            if (bus.sum_valid) begin
                hold_bcd  <= bus.sum_bcd;
                hold_cout <= bus.sum_cout;
                err_q     <= bcd_invalid(bus.sum_bcd);
            end

            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= next_digit(idx);
            end else begin
                presc <= presc + 1'b1;
            end

            if (presc < PW'(GHOST_CYC)) begin
                seg_q <= SEG_BLANK;
                an_q  <= AN_OFF;
            end else begin
                seg_q <= slot_seg;
                an_q  <= slot_an;
            end
            dp_q <= 1'b1;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.dp      = dp_q;
    assign bus.bcd_err = err_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Self-checking bench for bcd_sum_display (REFRESH_DIV=4, GHOST_CYC=1): a
// cycle model derived from time-since-reset plus directed literal checks.
module tb_bcd_sum_display;

    localparam int unsigned DIV   = 4;
    localparam int unsigned GHOST = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_sum_display_if bus ();

    bcd_sum_display #(
        .REFRESH_DIV (DIV),
        .GHOST_CYC   (GHOST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph table indexed by nibble value; anything above 9 is 'E'.
    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    int unsigned n;
    logic [7:0]  m_bcd;
    logic        m_cout;
    logic        m_err;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_err;
    int unsigned slot, phase, digit;
    logic [3:0]  tens, units;
    logic        lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank = 1'b1;
`else
    assign lz_blank = 1'b0;
`endif

    // Every edge the display position is a pure function of edges since reset.
    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_bcd = 8'h00; m_cout = 1'b0; m_err = 1'b0;
            e_seg = 7'h7F; e_an = 4'hF; e_err = 1'b0;
        end else begin
            slot  = n / DIV;
            phase = n % DIV;
            digit = slot % 4;
            tens  = m_bcd[7:4];
            units = m_bcd[3:0];
            if (phase < GHOST) begin
                e_seg = 7'h7F; e_an = 4'hF;
            end else begin
                e_an = ~(4'b0001 << digit);
                case (digit)
                    0: e_seg = pat[units];
                    1: e_seg = (lz_blank && !m_cout && tens == 4'd0) ? 7'h7F : pat[tens];
                    2: e_seg = (lz_blank && !m_cout) ? 7'h7F : (m_cout ? 7'h79 : 7'h40);
                    default: e_seg = m_err ? 7'h06 : 7'h7F;
                endcase
            end
            if (bus.sum_valid) begin
                m_bcd  = bus.sum_bcd;
                m_cout = bus.sum_cout;
                m_err  = (bus.sum_bcd[7:4] > 9) || (bus.sum_bcd[3:0] > 9);
            end
            e_err = m_err;
            n++;
        end
        #1;
        check("model_seg", 8'(bus.seg), 8'(e_seg));
        check("model_an", 8'(bus.an), 8'(e_an));
        check("model_dp", 8'(bus.dp), 8'h01);
        check("model_err", 8'(bus.bcd_err), 8'(e_err));
        check("an_onehot", 8'($countones(~bus.an) <= 1), 8'h01);
    end

    task automatic strobe(input logic [7:0] b, input logic c);
        @(negedge clk);
        bus.sum_valid = 1'b1; bus.sum_bcd = b; bus.sum_cout = c;
        @(negedge clk);
        bus.sum_valid = 1'b0;
    endtask

    // Wait (bounded) for the next cycle with the given anode; on entry into the
    // slot the preceding cycle must have been the ghost cycle.
    task automatic wait_lit(input logic [3:0] want, input logic [6:0] seg_exp, input string name);
        logic [3:0] prev;
        bit found;
        found = 0;
        prev  = bus.an;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            if (bus.an == want) begin
                found = 1;
                if (i > 0) check({name, "_ghost"}, 8'(prev), 8'h0F);
            end
            prev = bus.an;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s_timeout: an never reached %h", name, want);
        end else begin
            check(name, 8'(bus.seg), 8'(seg_exp));
        end
    endtask

    initial begin
        bus.sum_valid = 1'b0; bus.sum_bcd = 8'h00; bus.sum_cout = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_seg", 8'(bus.seg), 8'h7F);
        check("rst_an", 8'(bus.an), 8'h0F);
        check("rst_dp", 8'(bus.dp), 8'h01);
        check("rst_err", 8'(bus.bcd_err), 8'h00);
        rst = 1'b0;
        wait_lit(4'hE, 7'h40, "t1_first_lit");

        strobe(8'h95, 1'b1);
        @(negedge clk);
        wait_lit(4'hE, 7'h12, "t2_units5");
        wait_lit(4'hD, 7'h10, "t2_tens9");
        wait_lit(4'hB, 7'h79, "t2_hund1");
        wait_lit(4'h7, 7'h7F, "t2_status");

        strobe(8'h07, 1'b0);
        @(negedge clk);
        wait_lit(4'hE, 7'h78, "t3_units7");
`ifdef LEADING_ZERO_BLANK_EN
        wait_lit(4'hD, 7'h7F, "t3_tens_blank");
        wait_lit(4'hB, 7'h7F, "t3_hund_blank");
`else
        wait_lit(4'hD, 7'h40, "t3_tens0");
        wait_lit(4'hB, 7'h40, "t3_hund0");
`endif

        strobe(8'hA3, 1'b0);
        check("t4_err_set", 8'(bus.bcd_err), 8'h01);
        @(negedge clk);
        wait_lit(4'hD, 7'h06, "t4_tens_E");
        wait_lit(4'h7, 7'h06, "t4_status_E");
        wait_lit(4'hE, 7'h30, "t4_units3");
        strobe(8'h12, 1'b0);
        check("t4_err_clr", 8'(bus.bcd_err), 8'h00);

`ifdef LEADING_ZERO_BLANK_EN
        wait_lit(4'hB, 7'h7F, "t6_hund");
`else
        wait_lit(4'hB, 7'h40, "t6_hund");
`endif
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_seg", 8'(bus.seg), 8'h7F);
        check("t6_rst_an", 8'(bus.an), 8'h0F);
        check("t6_rst_err", 8'(bus.bcd_err), 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ghost_an", 8'(bus.an), 8'h0F);
        @(negedge clk);
        check("t6_idx0_an", 8'(bus.an), 8'h0E);
        check("t6_idx0_seg", 8'(bus.seg), 8'h40);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
